// File: rtl/mux_arbiter2.sv
// Two-requester arbiter feeding a registered 2:1 mux output with a valid/ready handshake.
// Optional round-robin tie-breaking is enabled by defining MUX_ARBITER2_ROUND_ROBIN_EN.
//
// state | meaning
// IDLE  | Out holds no valid data, OutValid=0
// HOLD0 | Out holds data captured from Input0
// HOLD1 | Out holds data captured from Input1
module mux_arbiter2 #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Resetn,
    input  logic             Req0,
    input  logic [WIDTH-1:0] Input0,
    output logic             Ack0,
    input  logic             Req1,
    input  logic [WIDTH-1:0] Input1,
    output logic             Ack1,
    output logic [WIDTH-1:0] Out,
    output logic             OutValid,
    input  logic             OutReady,
    output logic             Select
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD0 = 2'd1,
        HOLD1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             sel_q, sel_d;
    logic             capture;
    logic             winner;

`ifdef MUX_ARBITER2_ROUND_ROBIN_EN
    logic ptr_q, ptr_d;

    // Pointer names the requester that wins the next tie; it flips away from each grant.
    always_comb begin
        ptr_d = ptr_q;
        if (capture) begin
            ptr_d = ~winner;
        end
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic ptr_q;
    assign ptr_q = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        sel_d   = sel_q;
        Ack0    = 1'b0;
        Ack1    = 1'b0;
        // Resetn gates capture so no Ack can escape while reset is held.
        capture = Resetn && ((state_q == IDLE) || OutReady) && (Req0 || Req1);
        winner  = (Req0 && Req1) ? ptr_q : Req1;

        if (capture) begin
            out_d   = winner ? Input1 : Input0;
            sel_d   = winner;
            state_d = winner ? HOLD1 : HOLD0;
            Ack0    = ~winner;
            Ack1    = winner;
        end else if ((state_q != IDLE) && OutReady) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            out_q   <= '0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            sel_q   <= sel_d;
        end
    end

    assign Out      = out_q;
    assign OutValid = (state_q != IDLE);
    assign Select   = sel_q;

endmodule

// File: tb/tb_mux_arbiter2.sv
// Self-checking bench for mux_arbiter2: directed scenarios plus randomized traffic
// compared against a transaction-level model of the arbiter.
module tb_mux_arbiter2;

    logic        Clk = 1'b0;
    logic        Resetn;
    logic        Req0, Req1, OutReady;
    logic [31:0] Input0, Input1;
    logic        Ack0, Ack1, OutValid, Select;
    logic [31:0] Out;

    int checks = 0;
    int errors = 0;

    // Model: what the consumer sees and who is favoured on the next tie.
    bit          m_valid;
    bit          m_sel;
    bit          m_favour1;
    logic [31:0] m_out;

    mux_arbiter2 #(.WIDTH(32)) dut (
        .Clk(Clk), .Resetn(Resetn),
        .Req0(Req0), .Input0(Input0), .Ack0(Ack0),
        .Req1(Req1), .Input1(Input1), .Ack1(Ack1),
        .Out(Out), .OutValid(OutValid), .OutReady(OutReady), .Select(Select)
    );

    always #5 Clk = ~Clk;

    function automatic bit rr_enabled();
`ifdef MUX_ARBITER2_ROUND_ROBIN_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Returns 0 for no grant, 1 for requester 0, 2 for requester 1.
    function automatic int model_grant();
        if (m_valid && !OutReady) return 0;
        if (Req0 && Req1) return m_favour1 ? 2 : 1;
        if (Req0) return 1;
        if (Req1) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_valid   = 1'b0;
        m_sel     = 1'b0;
        m_favour1 = 1'b0;
        m_out     = '0;
    endtask

    task automatic drive(input bit r0, input logic [31:0] d0, input bit r1,
                         input logic [31:0] d1, input bit rdy);
        Req0 = r0; Input0 = d0; Req1 = r1; Input1 = d1; OutReady = rdy;
        #1;
    endtask

    task automatic tick();
        int g;
        g = model_grant();
        @(posedge Clk);
        if (g != 0) begin
            m_out   = (g == 2) ? Input1 : Input0;
            m_sel   = (g == 2);
            m_valid = 1'b1;
            m_favour1 = rr_enabled() ? (g == 1) : 1'b0;
        end else if (OutReady) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        Req0 = 0; Req1 = 0; OutReady = 0; Input0 = '0; Input1 = '0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1 Resetn = 1'b1;
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        Req0 = 1; Req1 = 1; OutReady = 1; Input0 = 32'h1234_5678; Input1 = 32'h8765_4321;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if (OutValid !== 1'b0 || Out !== 32'h0 || Select !== 1'b0 || Ack0 !== 1'b0 || Ack1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b out=%h sel=%b ack0=%b ack1=%b, required 0/0/0/0/0",
                     OutValid, Out, Select, Ack0, Ack1);
        end
        Req0 = 0; Req1 = 0; OutReady = 0;
        Resetn = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        drive(1, 32'hA5A5_0001, 0, 32'h0, 1);
        checks++;
        if (Ack0 !== 1'b1 || Ack1 !== 1'b0) begin
            errors++;
            $display("FAIL single_ack: ack0=%b ack1=%b, required 1/0", Ack0, Ack1);
        end
        tick();
        checks++;
        if (Out !== 32'hA5A5_0001 || OutValid !== 1'b1 || Select !== 1'b0) begin
            errors++;
            $display("FAIL single_out: out=%h valid=%b sel=%b, required a5a50001/1/0", Out, OutValid, Select);
        end
    endtask

    task automatic test_tie();
        bit exp1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h1000_0000 + i, 1, 32'h2000_0000 + i, 1);
            exp1 = rr_enabled() ? (i % 2 == 1) : 1'b0;
            checks++;
            if (Ack0 !== !exp1 || Ack1 !== exp1) begin
                errors++;
                $display("FAIL tie_ack[%0d]: ack0=%b ack1=%b, required %b/%b", i, Ack0, Ack1, !exp1, exp1);
            end
            tick();
            checks++;
            if (Select !== exp1 || Out !== (exp1 ? 32'h2000_0000 + i : 32'h1000_0000 + i)) begin
                errors++;
                $display("FAIL tie_out[%0d]: sel=%b out=%h, required sel %b", i, Select, Out, exp1);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        drive(1, 32'h0000_1111, 0, 32'h0, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 32'h0, 1, 32'hDEAD_BEEF, 0);
            checks++;
            if (Ack1 !== 1'b0 || Ack0 !== 1'b0) begin
                errors++;
                $display("FAIL stall_ack[%0d]: ack0=%b ack1=%b, required 0/0", i, Ack0, Ack1);
            end
            tick();
            checks++;
            if (Out !== 32'h0000_1111 || OutValid !== 1'b1 || Select !== 1'b0) begin
                errors++;
                $display("FAIL stall_out[%0d]: out=%h valid=%b sel=%b, required 00001111/1/0",
                         i, Out, OutValid, Select);
            end
        end
        drive(0, 32'h0, 1, 32'hDEAD_BEEF, 1);
        checks++;
        if (Ack1 !== 1'b1 || Ack0 !== 1'b0) begin
            errors++;
            $display("FAIL stall_release_ack: ack0=%b ack1=%b, required 0/1", Ack0, Ack1);
        end
        tick();
        checks++;
        if (Out !== 32'hDEAD_BEEF || Select !== 1'b1 || OutValid !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_out: out=%h sel=%b valid=%b, required deadbeef/1/1", Out, Select, OutValid);
        end
    endtask

    // Continues from HOLD1 left by test_stall.
    task automatic test_return_idle();
        drive(0, 32'h0, 0, 32'h0, 1);
        checks++;
        if (Ack0 !== 1'b0 || Ack1 !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack: ack0=%b ack1=%b, required 0/0", Ack0, Ack1);
        end
        tick();
        checks++;
        if (OutValid !== 1'b0 || Select !== 1'b1 || Out !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL idle_state: valid=%b sel=%b out=%h, required 0/1/deadbeef", OutValid, Select, Out);
        end
        drive(0, 32'h5555_5555, 0, 32'h6666_6666, 0);
        tick();
        checks++;
        if (OutValid !== 1'b0 || Select !== 1'b1 || Out !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL idle_hold: valid=%b sel=%b out=%h, required 0/1/deadbeef", OutValid, Select, Out);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1, 32'h0000_0077, 0, 32'h0, 1);
        tick();
        if (rr_enabled()) begin
            // Move the pointer to 1 first so the post-reset Ack0 proves Ptr was cleared.
            drive(1, 32'h0000_0078, 1, 32'h0000_0099, 1);
            tick();
            drive(1, 32'h0000_0079, 0, 32'h0, 1);
            tick();
        end
        drive(1, 32'h0000_0079, 1, 32'h0000_0099, 0);
        #2 Resetn = 1'b0;
        model_reset();
        #1;
        checks++;
        if (OutValid !== 1'b0 || Out !== 32'h0 || Select !== 1'b0 || Ack0 !== 1'b0 || Ack1 !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%b out=%h sel=%b ack0=%b ack1=%b, required all 0",
                     OutValid, Out, Select, Ack0, Ack1);
        end
        #1 Resetn = 1'b1;
        drive(1, 32'h0000_0079, 1, 32'h0000_0099, 1);
        checks++;
        if (Ack0 !== 1'b1 || Ack1 !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_ack: ack0=%b ack1=%b, required 1/0", Ack0, Ack1);
        end
        tick();
        checks++;
        if (Out !== 32'h0000_0079 || Select !== 1'b0 || OutValid !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_out: out=%h sel=%b valid=%b, required 00000079/0/1", Out, Select, OutValid);
        end
    endtask

    task automatic test_random();
        bit          r0, r1;
        logic [31:0] d0, d1;
        int          g;
        do_reset();
        r0 = 0; r1 = 0; d0 = '0; d1 = '0;
        for (int i = 0; i < 400; i++) begin
            // A requester keeps its request and data until acknowledged.
            if (!r0) begin r0 = ($urandom_range(0, 2) != 0); d0 = $urandom; end
            if (!r1) begin r1 = ($urandom_range(0, 2) != 0); d1 = $urandom; end
            drive(r0, d0, r1, d1, ($urandom_range(0, 3) != 0));
            g = model_grant();
            checks++;
            if (Ack0 !== (g == 1) || Ack1 !== (g == 2)) begin
                errors++;
                $display("FAIL rand_ack[%0d]: ack0=%b ack1=%b, required %b/%b", i, Ack0, Ack1, g == 1, g == 2);
            end
            tick();
            if (g == 1) r0 = 0;
            if (g == 2) r1 = 0;
            checks++;
            if (OutValid !== m_valid || Out !== m_out || Select !== m_sel) begin
                errors++;
                $display("FAIL rand_out[%0d]: valid=%b out=%h sel=%b, required %b/%h/%b",
                         i, OutValid, Out, Select, m_valid, m_out, m_sel);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_stall();
        test_return_idle();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
